// File: rtl/ma_stage_ctrl_pkg.sv
// Shared encodings for the RV32IM memory-access stage.
// Width codes, FSM states and the default ack timeout.
package ma_stage_ctrl_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned ACK_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ma_state_e;

endpackage

// File: rtl/ma_load_align.sv
// Load lane select and sign/zero extension.
// Purely combinational; offset comes from the latched address.
module ma_load_align
    import ma_stage_ctrl_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  func_3,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr, 3'b000} +: 8];
        lane_h = rdata[{addr[1], 4'b0000} +: 16];
        unique case (func_3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'd0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'd0, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/ma_stage_ctrl.sv
// Memory-access stage controller: req/ack data-memory FSM,
// store lane alignment, access faults and ack timeout.
module ma_stage_ctrl
    import ma_stage_ctrl_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] ALU_out,
    input  logic [31:0] DATA_2,
    input  logic [2:0]  func_3,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        mem_fault,
    output logic        bus_fault
);

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    ma_state_e   state;
    logic [7:0]  ack_cnt;
    logic [1:0]  lane_q;
    logic [2:0]  f3_q;
    logic [31:0] aligned;

    logic        access;
    logic        bad_f3;
    logic        misalign;
    logic        illegal;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    always_comb begin
        access   = mem_read | mem_write;
        bad_f3   = 1'b0;
        misalign = 1'b0;
        st_be    = 4'b0000;
        st_wdata = DATA_2;
        unique case (func_3)
            F3_B, F3_BU: begin
                st_be    = 4'b0001 << ALU_out[1:0];
                st_wdata = {4{DATA_2[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be    = 4'b0011 << ALU_out[1:0];
                st_wdata = {2{DATA_2[15:0]}};
                misalign = ALU_out[0];
            end
            F3_W: begin
                st_be    = 4'b1111;
                misalign = |ALU_out[1:0];
            end
            default: bad_f3 = 1'b1;
        endcase
        // unsigned widths have no store form
        illegal = bad_f3 | misalign
                | (mem_read & mem_write)
                | (mem_write & func_3[2]);
    end

    assign stall = ((state == IDLE) & access) | (state == BUSY);

    ma_load_align u_align (
        .addr   (lane_q),
        .func_3 (f3_q),
        .rdata  (dmem_rdata),
        .result (aligned)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            load_data  <= '0;
            mem_fault  <= 1'b0;
            bus_fault  <= 1'b0;
            ack_cnt    <= '0;
            lane_q     <= '0;
            f3_q       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (access && illegal) begin
                        mem_fault <= 1'b1;
                        load_data <= '0;
                        state     <= DONE;
                    end else if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mem_write;
                        dmem_addr  <= {ALU_out[31:2], 2'b00};
                        dmem_wdata <= st_wdata;
                        dmem_be    <= st_be;
                        lane_q     <= ALU_out[1:0];
                        f3_q       <= func_3;
                        ack_cnt    <= '0;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    // ack wins over a timeout in the same cycle
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we) begin
                            load_data <= aligned;
                        end
                        state <= DONE;
                    end else if (ack_cnt == TMO) begin
                        dmem_req  <= 1'b0;
                        dmem_we   <= 1'b0;
                        bus_fault <= 1'b1;
                        load_data <= '0;
                        state     <= DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                DONE: begin
                    mem_fault <= 1'b0;
                    bus_fault <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
